// File: rtl/muldiv_sched.sv
// muldiv_sched: sequencing controller for the EX-stage iterative mult/div datapath.
// Issues init/step strobes, commits into HI/LO on the final cycle and raises
// busy/stall so dependent HI/LO users wait for the result.
// Optional feature macro: MULDIV_DIVZERO_SKIP_EN (discard div/divu with a zero divisor).
module muldiv_sched #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mulOp,
    input  logic       mulWe,
    input  logic       HiLo,
    input  logic       rt_zero,
    input  logic       md_use_D,
    output logic       busy,
    output logic       stall_md,
    output logic       dp_init,
    output logic       dp_step,
    output logic       dp_signed,
    output logic       dp_div,
    output logic       hi_we,
    output logic       lo_we,
    output logic       hilo_src
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               sgn_q;
    logic               div_q;
    logic               accept_c;

    // Decide whether an issue in IDLE actually launches an operation
`ifdef MULDIV_DIVZERO_SKIP_EN
    assign accept_c = start & ~(mulOp[1] & rt_zero);
`else
    logic divzero_unused;
    assign accept_c       = start;
    assign divzero_unused = rt_zero;
`endif

    // State, iteration counter and latched operation attributes
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sgn_q <= 1'b0;
            div_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state <= RUN;
                        cnt   <= mulOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                        sgn_q <= ~mulOp[0];
                        div_q <= mulOp[1];
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes and status decoded from state; everything held low while in reset
    always_comb begin
        busy      = 1'b0;
        stall_md  = 1'b0;
        dp_init   = 1'b0;
        dp_step   = 1'b0;
        dp_signed = 1'b0;
        dp_div    = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hilo_src  = 1'b0;
        if (!reset) begin
            dp_signed = sgn_q;
            dp_div    = div_q;
            stall_md  = md_use_D & ((state == RUN) | start);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        dp_init = 1'b1;
                    end else if (mulWe && !start) begin
                        hilo_src = 1'b1;
                        hi_we    = HiLo;
                        lo_we    = ~HiLo;
                    end
                end
                RUN: begin
                    busy    = 1'b1;
                    dp_step = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        hi_we = 1'b1;
                        lo_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed testbench for muldiv_sched: per-cycle output vector checks
// {busy, stall_md, dp_init, dp_step, dp_signed, dp_div, hi_we, lo_we, hilo_src}.
module tb_muldiv_sched;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] mulOp;
    logic       mulWe;
    logic       HiLo;
    logic       rt_zero;
    logic       md_use_D;
    logic       busy;
    logic       stall_md;
    logic       dp_init;
    logic       dp_step;
    logic       dp_signed;
    logic       dp_div;
    logic       hi_we;
    logic       lo_we;
    logic       hilo_src;

    int errors = 0;
    int checks = 0;

    // Bench's own record of the latched attributes of the last launched op
    logic m_sgn = 1'b0;
    logic m_div = 1'b0;

    muldiv_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mulOp     (mulOp),
        .mulWe     (mulWe),
        .HiLo      (HiLo),
        .rt_zero   (rt_zero),
        .md_use_D  (md_use_D),
        .busy      (busy),
        .stall_md  (stall_md),
        .dp_init   (dp_init),
        .dp_step   (dp_step),
        .dp_signed (dp_signed),
        .dp_div    (dp_div),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hilo_src  (hilo_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] outs();
        return {busy, stall_md, dp_init, dp_step, dp_signed, dp_div, hi_we, lo_we, hilo_src};
    endfunction

    function automatic logic [8:0] ex(input logic b, input logic s, input logic i, input logic st,
                                      input logic h, input logic l, input logic src);
        return {b, s, i, st, m_sgn, m_div, h, l, src};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        reset = 1'b1; start = 1'b1; mulWe = 1'b1; md_use_D = 1'b1; mulOp = 2'b10;
        exp = 9'b0;
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL reset_active got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        reset = 1'b0; start = 1'b0; mulWe = 1'b0; md_use_D = 1'b0; mulOp = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL reset_idle k=%0d got=%b exp=%b", k, outs(), exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_mult();
        logic [8:0] exp;
        md_use_D = 1'b1; start = 1'b1; mulOp = 2'b00;
        exp = ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL mult_issue got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        start = 1'b0; m_sgn = 1'b1; m_div = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 5) exp = ex(1'b1, 1'b1, 1'b0, 1'b1, k == 5, k == 5, 1'b0);
            else        exp = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL mult T+%0d got=%b exp=%b", k, outs(), exp);
            end
            next_cycle();
        end
        md_use_D = 1'b0;
    endtask

    task automatic test_divu();
        logic [8:0] exp;
        start = 1'b1; mulOp = 2'b11; rt_zero = 1'b0;
        exp = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL divu_issue got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        start = 1'b0; m_sgn = 1'b0; m_div = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k <= 10) exp = ex(1'b1, 1'b0, 1'b0, 1'b1, k == 10, k == 10, 1'b0);
            else         exp = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL divu T+%0d got=%b exp=%b", k, outs(), exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [8:0] exp;
        md_use_D = 1'b1; mulWe = 1'b1; HiLo = 1'b0;
        exp = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL mtlo got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        HiLo = 1'b1;
        exp = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL mthi got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        mulWe = 1'b0; HiLo = 1'b0;
        exp = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL mtxx_after got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        md_use_D = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [8:0] exp;
        start = 1'b1; mulOp = 2'b10; rt_zero = 1'b0;
        exp = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL rmid_issue got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        start = 1'b0; m_sgn = 1'b1; m_div = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            exp = ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL rmid_run T+%0d got=%b exp=%b", k, outs(), exp);
            end
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; m_sgn = 1'b0; m_div = 1'b0;
        exp = 9'b0;
        for (int k = 4; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL rmid_quiet T+%0d got=%b exp=%b", k, outs(), exp);
            end
            next_cycle();
        end
        start = 1'b1; mulOp = 2'b00;
        exp = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL rmid_mult_issue got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        start = 1'b0; m_sgn = 1'b1; m_div = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 5) exp = ex(1'b1, 1'b0, 1'b0, 1'b1, k == 5, k == 5, 1'b0);
            else        exp = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL rmid_mult T+%0d got=%b exp=%b", k, outs(), exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_divzero();
        logic [8:0] exp;
        md_use_D = 1'b1; start = 1'b1; mulOp = 2'b10; rt_zero = 1'b1;
`ifdef MULDIV_DIVZERO_SKIP_EN
        exp = ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL dz_issue got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        start = 1'b0; rt_zero = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            exp = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL dz_skip T+%0d got=%b exp=%b", k, outs(), exp);
            end
            next_cycle();
        end
`else
        exp = ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL dz_issue got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        start = 1'b0; rt_zero = 1'b0; m_sgn = 1'b1; m_div = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k <= 10) exp = ex(1'b1, 1'b1, 1'b0, 1'b1, k == 10, k == 10, 1'b0);
            else         exp = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL dz_run T+%0d got=%b exp=%b", k, outs(), exp);
            end
            next_cycle();
        end
`endif
        md_use_D = 1'b0;
    endtask

    task automatic test_busy_ignore();
        logic [8:0] exp;
        start = 1'b1; mulOp = 2'b00;
        exp = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL ign_issue got=%b exp=%b", outs(), exp);
        end
        next_cycle();
        start = 1'b0; m_sgn = 1'b1; m_div = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            // stray div issue and mthi while busy must be ignored
            start = (k == 2 || k == 3);
            mulWe = (k == 3);
            mulOp = (k == 2 || k == 3) ? 2'b11 : 2'b00;
            HiLo  = 1'b1;
            if (k <= 5) exp = ex(1'b1, 1'b0, 1'b0, 1'b1, k == 5, k == 5, 1'b0);
            else        exp = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL ignore T+%0d got=%b exp=%b", k, outs(), exp);
            end
            next_cycle();
        end
        start = 1'b0; mulWe = 1'b0; HiLo = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mulOp = 2'b00; mulWe = 1'b0;
        HiLo = 1'b0; rt_zero = 1'b0; md_use_D = 1'b0;
        next_cycle();
        next_cycle();
        test_reset();
        test_mult();
        test_divu();
        test_mthi_mtlo();
        test_reset_mid_op();
        test_divzero();
        test_busy_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencing controller for the iterative multiply/divide datapath in the EX stage of the pipelined MIPS core. It accepts a `start` from EX control and runs the operation for a fixed, op-dependent number of cycles. It drives the datapath's init/step strobes and commits the result into HI/LO on the final cycle. It also supplies `busy` and a multiply/divide stall request to the pipeline stall logic, so that later HI/LO users wait for the result.

## Interface
Parameters:
- `MUL_CYCLES`, default 5: busy cycles for mult/multu; legal range ≥1.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  EX-stage mult/multu/div/divu issue.
- `mulOp`  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- `mulWe`  in  1  EX-stage mthi/mtlo.
- `HiLo`  in  1  mthi/mtlo target: 1 = HI, 0 = LO.
- `rt_zero`  in  1  EX-stage divisor equals 0.
- `md_use_D`  in  1  ID-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `busy`  out  1  operation in progress.
- `stall_md`  out  1  stall request to the pipeline.
- `dp_init`  out  1  datapath loads its operands from EX forwarding muxes.
- `dp_step`  out  1  datapath advances one iteration.
- `dp_signed`  out  1  latched signedness: 1 for mult/div.
- `dp_div`  out  1  latched operation class: 1 = divide.
- `hi_we`  out  1  HI register write enable.
- `lo_we`  out  1  LO register write enable.
- `hilo_src`  out  1  HI/LO write source: 0 = datapath result, 1 = mthi/mtlo operand.

## Operation
- FSM with two states, IDLE and RUN. A down-counter `cnt` is sized for `max(MUL_CYCLES, DIV_CYCLES)`.
- IDLE, `start` = 1:
  - `dp_init` = 1 combinationally in the same cycle.
  - At the edge: latch `dp_signed = ~mulOp[0]` and `dp_div = mulOp[1]`.
  - At the edge: load `cnt` with `DIV_CYCLES` if `mulOp[1]` = 1, else `MUL_CYCLES`.
  - At the edge: go to RUN.
- IDLE, `mulWe` = 1 and `start` = 0:
  - `hilo_src` = 1 combinationally.
  - `hi_we` = `HiLo`, `lo_we` = ~`HiLo`.
  - State does not change.
- IDLE, `start` and `mulWe` both 1: illegal, since decode never issues both. `start` wins and `mulWe` is ignored.
- RUN:
  - `busy` = 1 and `dp_step` = 1 every cycle; `cnt` decrements each edge.
  - When `cnt` = 1: `hi_we` = `lo_we` = 1 with `hilo_src` = 0; next state IDLE.
- RUN ignores `start` and `mulWe`. The stall logic guarantees neither is issued while busy, so the pipeline must not rely on them.
- `stall_md = md_use_D & (busy | start)`. This holds any dependent instruction in ID until the result has committed.
- Outside the cases above, `dp_init`, `dp_step`, `hi_we` and `lo_we` are 0.

## Timing
- Issue in cycle T:
  - `busy` = 1 in cycles T+1 … T+N, where N = `MUL_CYCLES` or `DIV_CYCLES` for the issued op.
  - HI/LO commit strobes are asserted in cycle T+N.
  - The new HI/LO value is visible at T+N+1, which is also the first cycle with `busy` = 0.
- A back-to-back issue is legal at T+N+1.
- mthi/mtlo has zero latency: the write strobes are in the issue cycle, and the register updates at its end.
- Reset:
  - Values: state IDLE, `cnt` = 0, `dp_signed` = 0, `dp_div` = 0.
  - All outputs are 0 during and after reset until the next issue.
  - A reset mid-RUN aborts the operation with no commit strobe.
- Counter wrap is impossible: `cnt` only loads from IDLE and stops at 1.

## Configuration
- `MULDIV_DIVZERO_SKIP_EN` defined:
  - A div/divu issued in IDLE with `rt_zero` = 1 is discarded.
  - No RUN state, `busy` stays 0, no `dp_init` and no commit, so HI/LO are unchanged.
  - `stall_md` still follows `md_use_D & start` in the issue cycle.
- `MULDIV_DIVZERO_SKIP_EN` undefined:
  - Divide-by-zero runs the full `DIV_CYCLES` and commits whatever the datapath produces. The architectural result is UNPREDICTABLE.

## Test plan
- **mult**: reset, then `start`=1, `mulOp`=00 at T.
  - Required: `dp_init`=1 at T; `busy`=1 at T+1…T+5; `hi_we`=`lo_we`=1 only at T+5; `busy`=0 at T+6; `dp_signed`=1, `dp_div`=0.
- **divu**: `start`, `mulOp`=11, `rt_zero`=0.
  - Required: `busy` high for exactly 10 cycles; single commit at T+10; `dp_signed`=0, `dp_div`=1.
- **Stall and mthi/mtlo**:
  - `md_use_D`=1 throughout a mult → `stall_md`=1 at T…T+5 and 0 at T+6.
  - An mtlo (`mulWe`=1, `HiLo`=0) in IDLE → `lo_we`=1, `hi_we`=0, `hilo_src`=1 in that cycle.
- **Reset mid-op**: assert `reset` at T+3 of a div.
  - Required: `busy`=0 the next cycle; no `hi_we`/`lo_we` pulse ever; a fresh mult issued afterwards completes normally in 5 cycles.
- **Divide by zero**: div with `rt_zero`=1.
  - With the macro: `busy` never rises and no commit strobe.
  - Without the macro: 10 busy cycles and a commit at T+10.
- **Ignored issue while busy**: assert `start` during RUN of a mult.
  - Required: ignored; the commit still occurs at original T+5 and `cnt` is not reloaded.
